imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Inverse of the core's immediate decode. It packs opcode, funct, register fields and a full 32-bit signed immediate into an RV32I instruction word for one of the formats R/I/S/B/U/J.
- Checks immediate range and alignment, and tags each output word with a sequential instruction address.
- Sits between the boot/debug program loader and instruction-memory write port.
- Two-stage pipeline with valid/ready on both sides.

Parameters:
- ADDR_W, 32, width of instruction address counter and out_addr.
- ERR_CNT_W, 8, width of saturating error counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input request valid.
- in_ready  out  1  encoder can accept request this cycle.
- fmt  in  3  0=R,1=I,2=S,3=B,4=U,5=J; 6,7 illegal.
- opcode  in  7  placed at instr[6:0].
- funct3  in  3  placed at instr[14:12] (R/I/S/B).
- funct7  in  7  placed at instr[31:25] (R only).
- rd  in  5  instr[11:7] (R/I/U/J).
- rs1  in  5  instr[19:15] (R/I/S/B).
- rs2  in  5  instr[24:20] (R/S/B).
- imm  in  32  full signed byte-offset/value immediate.
- base_load  in  1  load address counter from base_addr.
- base_addr  in  ADDR_W  new counter value.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts word.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  address assigned to out_instr.
- out_err  out  1  request failed range/alignment/format check.
- err_count  out  ERR_CNT_W  saturating count of errored words delivered.

Behaviour:
- Reset (rst_n low at edge): both stage valids 0, out_valid=0, out_instr=0, out_err=0, address counter=0, err_count=0.
- in_ready is 1 during reset cycles. Reset mid-transfer discards all in-flight data.
- Handshakes:
  - Input accepted when in_valid & in_ready.
  - Output consumed when out_valid & out_ready.
  - out_* hold stable while out_valid & !out_ready.
- Pipeline:
  - S1 registers the request and computes the error flag.
  - S2 registers the packed word and err, and drives out_*.
  - A stage loads when it is empty or its content moves forward that cycle.
  - in_ready = !s1_valid | (s1 advances this cycle).
  - Full throughput 1/cycle. Latency: accept at edge N gives out_valid at edge N+2 when out_ready stays high.
  - Holds up to 2 requests under backpressure, so in_ready falls after 2 unconsumed accepts.
- Checks (err=1 if violated):
  - I,S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]==0.
  - J: imm[31:20] all equal and imm[0]==0.
  - U: imm[11:0]==0.
  - R: imm ignored, never errors.
  - fmt 6/7: always err.
- Packing:
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
  - Unused input fields are ignored.
- On err: out_instr=32'h00000013 (canonical NOP), out_err=1.
- Address:
  - out_addr = current counter value.
  - Counter += 4 on each output handshake, wrapping modulo 2^ADDR_W.
  - base_load sets the counter to base_addr next edge and takes priority over the increment. A word handshaken in the same cycle keeps the old address.
  - base_load does not touch pipeline contents.
- err_count increments on output handshake of an errored word and saturates at all-ones.

Test Plan:
- I-type, opcode 0x13, rd=1, rs1=2, funct3=0, imm=-1, out_ready=1 -> two cycles later out_instr=0xFFF10093, out_err=0, out_addr=0.
- B-type, opcode 0x63, rs1=1, rs2=2, funct3=0, imm=8 -> 0x00208463. J-type, opcode 0x6F, rd=1, imm=-4 -> 0xFFDFF0EF. U-type, opcode 0x37, rd=5, imm=0x12345000 -> 0x123452B7.
- Errors:
  - I with imm=2048 -> out_instr=0x00000013, out_err=1, err_count=1.
  - B with imm=6... imm=7 -> err, err_count=2.
  - fmt=6 -> err.
  - 300 errored words -> err_count stays 255.
- Backpressure: stream 5 back-to-back valid requests with out_ready=0 for 4 cycles. After 2 accepts, in_ready=0 and out_* stay stable. Release out_ready -> all 5 words delivered in order, none lost or duplicated.
- Address: base_load=1 with base_addr=0x100, then 3 words -> out_addr 0x100, 0x104, 0x108. base_load=0x0 in the same cycle as a handshake -> that word keeps its old address, next word gets 0x0. Counter at 0xFFFFFFFC increments to 0x0.
- Reset: assert rst_n=0 for 1 cycle with 2 words in flight -> out_valid=0, err_count=0, counter=0 next cycle. No stale word appears afterward.

Source files
------------

// File: rtl/imm_encoder_if.sv
// Request/response bundle between the program loader and the RV32I immediate encoder.
// Handshake: a word moves on any rising edge where valid & ready are both high; the
// producer holds valid and its payload steady until it moves, and ready may depend on valid.
interface imm_encoder_if #(
  parameter int ADDR_W    = 32,
  parameter int ERR_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           fmt;
  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [6:0]           funct7;
  logic [4:0]           rd;
  logic [4:0]           rs1;
  logic [4:0]           rs2;
  logic [31:0]          imm;
  logic                 base_load;
  logic [ADDR_W-1:0]    base_addr;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_instr;
  logic [ADDR_W-1:0]    out_addr;
  logic                 out_err;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm,
    output base_load, base_addr, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err, err_count
  );

  modport slave (
    input  in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm,
    input  base_load, base_addr, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err, err_count
  );
endinterface

// File: rtl/imm_encoder.sv
// Two-stage RV32I instruction packer: S1 holds the request and its range/alignment
// verdict, S2 holds the packed word, tagged with a running instruction address.
module imm_encoder #(
  parameter int ADDR_W    = 32,
  parameter int ERR_CNT_W = 8
) (
  input logic         clk,
  input logic         rst_n,
  imm_encoder_if.slave bus
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  logic                 s1_valid;
  logic [2:0]           s1_fmt;
  logic [6:0]           s1_opcode;
  logic [2:0]           s1_funct3;
  logic [6:0]           s1_funct7;
  logic [4:0]           s1_rd;
  logic [4:0]           s1_rs1;
  logic [4:0]           s1_rs2;
  logic [31:0]          s1_imm;
  logic                 s1_err;

  logic                 s2_valid;
  logic [31:0]          s2_instr;
  logic                 s2_err;

  logic [ADDR_W-1:0]    addr_cnt;
  logic [ERR_CNT_W-1:0] err_cnt;

  logic                 out_fire;
  logic                 s2_load_en;
  logic                 in_fire;
  logic                 in_err;
  logic [31:0]          packed_word;

  // S2 can take a new word when empty or draining; S1 frees whenever S2 takes its word.
  assign out_fire   = s2_valid & bus.out_ready;
  assign s2_load_en = !s2_valid | bus.out_ready;
  assign bus.in_ready = !rst_n | !s1_valid | s2_load_en;
  assign in_fire    = bus.in_valid & bus.in_ready;

  assign bus.out_valid = s2_valid;
  assign bus.out_instr = s2_instr;
  assign bus.out_err   = s2_err;
  assign bus.out_addr  = addr_cnt;
  assign bus.err_count = err_cnt;

  // An immediate fits a field when every bit above the field's sign bit copies it.
  always_comb begin
    in_err = 1'b0;
    case (bus.fmt)
      FMT_R:        in_err = 1'b0;
      FMT_I, FMT_S: in_err = !((&bus.imm[31:11]) | ~(|bus.imm[31:11]));
      FMT_B:        in_err = !((&bus.imm[31:12]) | ~(|bus.imm[31:12])) | bus.imm[0];
      FMT_U:        in_err = |bus.imm[11:0];
      FMT_J:        in_err = !((&bus.imm[31:20]) | ~(|bus.imm[31:20])) | bus.imm[0];
      default:      in_err = 1'b1;
    endcase
  end

  always_comb begin
    packed_word = NOP;
    case (s1_fmt)
      FMT_R: packed_word = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
      FMT_I: packed_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
      FMT_S: packed_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
      FMT_B: packed_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                            s1_imm[4:1], s1_imm[11], s1_opcode};
      FMT_U: packed_word = {s1_imm[31:12], s1_rd, s1_opcode};
      FMT_J: packed_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                            s1_rd, s1_opcode};
      default: packed_word = NOP;
    endcase
    if (s1_err) packed_word = NOP;
  end

  // Request payload needs no reset: it is only observed behind s1_valid.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_fmt    <= bus.fmt;
      s1_opcode <= bus.opcode;
      s1_funct3 <= bus.funct3;
      s1_funct7 <= bus.funct7;
      s1_rd     <= bus.rd;
      s1_rs1    <= bus.rs1;
      s1_rs2    <= bus.rs2;
      s1_imm    <= bus.imm;
      s1_err    <= in_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_instr <= '0;
      s2_err   <= 1'b0;
      addr_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (bus.in_ready) s1_valid <= bus.in_valid;
      if (s2_load_en) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_instr <= packed_word;
          s2_err   <= s1_err;
        end
      end
      // A word leaving in the same cycle as base_load keeps the address it was shown with.
      if (bus.base_load)  addr_cnt <= bus.base_addr;
      else if (out_fire)  addr_cnt <= addr_cnt + ADDR_W'(4);
      if (out_fire && s2_err && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Randomized and directed stimulus for imm_encoder; expected words come from a
// format-rule reference model and are matched in order by an output monitor.
module tb_imm_encoder;
  localparam int ADDR_W    = 32;
  localparam int ERR_CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imm_encoder_if #(.ADDR_W(ADDR_W), .ERR_CNT_W(ERR_CNT_W)) bus ();

  imm_encoder #(.ADDR_W(ADDR_W), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [32:0]          exp_q[$];
  logic                 fixed_en   = 1'b0;
  logic [32:0]          fixed_word = '0;
  logic [ADDR_W-1:0]    m_addr     = '0;
  logic [ERR_CNT_W-1:0] m_errc     = '0;
  logic                 stall_prev = 1'b0;
  logic [32:0]          stall_word = '0;
  logic [32:0]          mon_e;
  logic                 rand_on    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: range as signed arithmetic on the byte offset, then field placement.
  function automatic logic [32:0] ref_encode(input logic [2:0] f, input logic [6:0] op,
      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rdv,
      input logic [4:0] rs1v, input logic [4:0] rs2v, input logic [31:0] immv);
    longint s;
    logic   bad;
    logic [31:0] w;
    s   = longint'($signed(immv));
    bad = 1'b0;
    w   = 32'h0000_0013;
    case (f)
      3'd0: w = {f7, rs2v, rs1v, f3, rdv, op};
      3'd1: begin
        bad = (s < -2048) || (s > 2047);
        w   = {immv[11:0], rs1v, f3, rdv, op};
      end
      3'd2: begin
        bad = (s < -2048) || (s > 2047);
        w   = {immv[11:5], rs2v, rs1v, f3, immv[4:0], op};
      end
      3'd3: begin
        bad = (s < -4096) || (s > 4095) || (s % 2 != 0);
        w   = {immv[12], immv[10:5], rs2v, rs1v, f3, immv[4:1], immv[11], op};
      end
      3'd4: begin
        bad = (immv % 32'd4096) != 0;
        w   = {immv[31:12], rdv, op};
      end
      3'd5: begin
        bad = (s < -1048576) || (s > 1048575) || (s % 2 != 0);
        w   = {immv[20], immv[10:1], immv[11], immv[19:12], rdv, op};
      end
      default: bad = 1'b1;
    endcase
    if (bad) return {1'b1, 32'h0000_0013};
    return {1'b0, w};
  endfunction

  // Input-side scoreboard feed: one expected word per accepted request.
  always @(negedge clk) begin
    if (rst_n && bus.in_valid && bus.in_ready)
      exp_q.push_back(fixed_en ? fixed_word :
        ref_encode(bus.fmt, bus.opcode, bus.funct3, bus.funct7, bus.rd, bus.rs1, bus.rs2, bus.imm));
  end

  // Output monitor: order, stability under stall, address and error-count models.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_addr     = '0;
      m_errc     = '0;
      stall_prev = 1'b0;
    end else begin
      check("err_count", 64'(bus.err_count), 64'(m_errc));
      if (stall_prev) begin
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        check("stall_word", 64'({bus.out_err, bus.out_instr}), 64'(stall_word));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: got %h expected none", {bus.out_err, bus.out_instr});
        end else begin
          mon_e = exp_q.pop_front();
          check("word", 64'({bus.out_err, bus.out_instr}), 64'(mon_e));
          check("addr", 64'(bus.out_addr), 64'(m_addr));
          if (mon_e[32] && m_errc != '1) m_errc = m_errc + 1'b1;
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_word = {bus.out_err, bus.out_instr};
      if (bus.base_load)                        m_addr = bus.base_addr;
      else if (bus.out_valid && bus.out_ready)  m_addr = m_addr + ADDR_W'(4);
    end
  end

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] rdv, input logic [4:0] rs1v,
      input logic [4:0] rs2v, input logic [31:0] immv);
    logic acc;
    bus.in_valid = 1'b1;
    bus.fmt = f; bus.opcode = op; bus.funct3 = f3; bus.funct7 = f7;
    bus.rd = rdv; bus.rs1 = rs1v; bus.rs2 = rs2v; bus.imm = immv;
    acc = 1'b0;
    for (int t = 0; t < 300 && !acc; t++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 300 cycles");
    end
  endtask

  task automatic send_fixed(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
      input logic [4:0] rdv, input logic [4:0] rs1v, input logic [4:0] rs2v,
      input logic [31:0] immv, input logic [32:0] word);
    fixed_en   = 1'b1;
    fixed_word = word;
    send(f, op, f3, 7'h00, rdv, rs1v, rs2v, immv);
    fixed_en   = 1'b0;
  endtask

  task automatic send_rand(input logic [2:0] f);
    logic [31:0] immv;
    case ($urandom_range(0, 2))
      0:       immv = $urandom;
      1:       immv = 32'($urandom_range(0, 8191)) - 32'd4096;
      default: immv = $urandom & 32'hFFFF_F000;
    endcase
    send(f, 7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
         5'($urandom), immv);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    for (t = 0; t < 1000 && exp_q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_base(input logic [ADDR_W-1:0] a);
    bus.base_addr = a;
    bus.base_load = 1'b1;
    @(posedge clk);
    #1;
    bus.base_load = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.fmt = '0; bus.opcode = '0; bus.funct3 = '0; bus.funct7 = '0;
    bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.imm = '0;
    bus.base_load = 1'b0; bus.base_addr = '0; bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_instr", 64'(bus.out_instr), 64'd0);
    check("rst_out_err", 64'(bus.out_err), 64'd0);
    check("rst_out_addr", 64'(bus.out_addr), 64'd0);
    @(posedge clk);
    #1;

    // Directed encodings
    send_fixed(3'd1, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, {1'b0, 32'hFFF1_0093});
    send_fixed(3'd3, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8, {1'b0, 32'h0020_8463});
    send_fixed(3'd5, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFC, {1'b0, 32'hFFDF_F0EF});
    send_fixed(3'd4, 7'h37, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, {1'b0, 32'h1234_52B7});
    idle();
    wait_drain();

    // Errored requests
    send_fixed(3'd1, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0, 32'd2048, {1'b1, 32'h0000_0013});
    send_fixed(3'd3, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd7, {1'b1, 32'h0000_0013});
    send_fixed(3'd6, 7'h33, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, {1'b1, 32'h0000_0013});
    idle();
    wait_drain();
    check("err_count_3", 64'(bus.err_count), 64'd3);
    for (int i = 0; i < 300; i++) send_rand(3'd7);
    idle();
    wait_drain();
    check("err_count_sat", 64'(bus.err_count), 64'd255);

    // Backpressure: two held, third stalls, outputs frozen, then all delivered in order
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send_rand(3'd1);
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        check("bp_held", 64'(exp_q.size()), 64'd2);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();

    // Address counter: base load, base load coincident with a handshake, wrap
    load_base(32'h0000_0100);
    for (int i = 0; i < 3; i++) send_rand(3'd0);
    idle();
    wait_drain();
    check("addr_after_3", 64'(bus.out_addr), 64'h10C);
    bus.out_ready = 1'b0;
    send_rand(3'd0);
    idle();
    for (int t = 0; t < 10 && !bus.out_valid; t++) begin
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    load_base(32'h0000_0000);
    send_rand(3'd0);
    idle();
    wait_drain();
    check("addr_after_base0", 64'(bus.out_addr), 64'h4);
    load_base(32'hFFFF_FFFC);
    send_rand(3'd2);
    send_rand(3'd4);
    idle();
    wait_drain();
    check("addr_wrap", 64'(bus.out_addr), 64'h4);

    // Randomized traffic with random consumer stalls
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int i = 0; i < 200; i++) begin
          send_rand(3'($urandom_range(0, 7)));
          if ($urandom_range(0, 4) == 0) begin
            idle();
            @(posedge clk);
            #1;
          end
        end
        idle();
        rand_on = 1'b0;
      end
    join
    bus.out_ready = 1'b1;
    wait_drain();

    // Reset with two words in flight
    bus.out_ready = 1'b0;
    send_rand(3'd1);
    send_rand(3'd5);
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_err_count", 64'(bus.err_count), 64'd0);
    check("mid_rst_addr", 64'(bus.out_addr), 64'd0);
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    send_rand(3'd3);
    idle();
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
